// File: rtl/result_src_arbiter_if.sv
// Writeback result-path bundle: four requester lanes in, one registered writeback entry out.
// The slave modport is the arbiter side; the master modport drives requests and consumes writeback.
interface result_src_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [3:0]              i_req_valid;
    logic [4*DATA_WIDTH-1:0] i_req_data;
    logic [4*ADDR_WIDTH-1:0] i_req_rd;
    logic [3:0]              o_req_ready;
    logic [1:0]              o_result_src;
    logic                    o_wb_valid;
    logic [DATA_WIDTH-1:0]   o_wb_data;
    logic [ADDR_WIDTH-1:0]   o_wb_rd;
    logic                    i_wb_ready;
    logic                    o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_req_rd, i_wb_ready,
        output o_req_ready, o_result_src, o_wb_valid, o_wb_data, o_wb_rd, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_req_rd, i_wb_ready,
        input  o_req_ready, o_result_src, o_wb_valid, o_wb_data, o_wb_rd, o_busy
    );
endinterface

// File: rtl/result_src_arbiter.sv
// Four-way arbiter for the writeback result mux with a single-entry output register.
// Default is fixed priority load > ALU > CSR/imm > PC+4; define RESULT_ARB_RR_EN for round-robin.
//
// state    | meaning
// ST_EMPTY | no writeback entry held (o_wb_valid = 0)
// ST_FULL  | entry held and presented to writeback (o_wb_valid = 1)
module result_src_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    result_src_arbiter_if.slave   bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [ADDR_WIDTH-1:0] r_wb_rd;
    logic [1:0]            r_result_src;

    logic                  w_can_accept;
    logic                  w_grant_vld;
    logic [1:0]            w_grant_idx;
    logic                  w_fire;
    logic [3:0]            w_grant;

    assign w_can_accept = (r_state == ST_EMPTY) || bus.i_wb_ready;

`ifdef RESULT_ARB_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_scan;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = 2'd0;
        w_scan      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_scan = r_ptr + 2'(i);
            if (!w_grant_vld && bus.i_req_valid[w_scan]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_fire) begin
            r_ptr <= w_grant_idx + 2'd1;
        end
    end
`else
    always_comb begin
        w_grant_vld = 1'b1;
        w_grant_idx = 2'd0;
        if (bus.i_req_valid[1]) begin
            w_grant_idx = 2'd1;
        end else if (bus.i_req_valid[0]) begin
            w_grant_idx = 2'd0;
        end else if (bus.i_req_valid[3]) begin
            w_grant_idx = 2'd3;
        end else if (bus.i_req_valid[2]) begin
            w_grant_idx = 2'd2;
        end else begin
            w_grant_vld = 1'b0;
        end
    end
`endif

    // Reset blocks the grant so a request is never consumed by a cycle that drops its entry.
    assign w_fire  = w_grant_vld && w_can_accept && !rst;
    assign w_grant = w_fire ? (4'b0001 << w_grant_idx) : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_fire) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_fire) begin
                    w_state_nxt = ST_FULL;
                end else if (bus.i_wb_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_result_src <= 2'd0;
        end else if (w_fire) begin
            r_wb_data    <= bus.i_req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_wb_rd      <= bus.i_req_rd[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_result_src <= w_grant_idx;
        end
    end

    assign bus.o_req_ready  = w_grant;
    assign bus.o_wb_valid   = (r_state == ST_FULL);
    assign bus.o_wb_data    = r_wb_data;
    assign bus.o_wb_rd      = r_wb_rd;
    assign bus.o_result_src = r_result_src;
    assign bus.o_busy       = (r_state == ST_FULL) || (|bus.i_req_valid);

endmodule

// File: tb/tb_result_src_arbiter.sv
// Directed bench for result_src_arbiter: expected writeback entries go into a scoreboard queue
// at grant time and a negedge monitor pops them whenever a writeback transfer happens.
module tb_result_src_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic [1:0]    src;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    result_src_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    result_src_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] d, input logic [AW-1:0] rd);
        bus.i_req_data[k*DW +: DW] = d;
        bus.i_req_rd[k*AW +: AW]   = rd;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] rd, input logic [1:0] src);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.src  = src;
        sb.push_back(e);
    endtask

    // Writeback monitor: a transfer is o_wb_valid & i_wb_ready at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && bus.o_wb_valid && bus.i_wb_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_entry", 64'(bus.o_wb_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", bus.o_wb_data, e.data);
                chk("sb_rd", 64'(bus.o_wb_rd), 64'(e.rd));
                chk("sb_src", 64'(bus.o_result_src), 64'(e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int n_order;

        rst              = 1'b1;
        bus.i_req_valid  = 4'hF;
        bus.i_req_data   = '0;
        bus.i_req_rd     = '0;
        bus.i_wb_ready   = 1'b0;

        // Reset with all requesters valid
        tick();
        #1 chk("rst_ready", 64'(bus.o_req_ready), 64'h0);
        tick();
        chk("rst_ready2", 64'(bus.o_req_ready), 64'h0);
        chk("rst_wb_valid", 64'(bus.o_wb_valid), 64'h0);
        chk("rst_src", 64'(bus.o_result_src), 64'h0);
        chk("rst_data", bus.o_wb_data, 64'h0);
        chk("rst_rd", 64'(bus.o_wb_rd), 64'h0);
        chk("rst_busy", 64'(bus.o_busy), 64'h1);
        rst             = 1'b0;
        bus.i_req_valid = 4'h0;
        #1 chk("idle_busy", 64'(bus.o_busy), 64'h0);

        // Single ALU request
        set_req(0, 64'hDEAD_BEEF, 5'd5);
        bus.i_req_valid = 4'b0001;
        bus.i_wb_ready  = 1'b1;
        #1 chk("single_ready", 64'(bus.o_req_ready), 64'h1);
        push(64'hDEAD_BEEF, 5'd5, 2'd0);
        tick();
        bus.i_req_valid = 4'h0;
        chk("single_wb_valid", 64'(bus.o_wb_valid), 64'h1);
        chk("single_data", bus.o_wb_data, 64'hDEAD_BEEF);
        tick();
        chk("single_drained", 64'(bus.o_wb_valid), 64'h0);

        // Contention from a fresh reset so the round-robin pointer is 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 64'h1000 + 64'(k), 5'(10 + k));
        bus.i_req_valid = 4'hF;
`ifdef RESULT_ARB_RR_EN
        order   = '{0, 1, 2, 3, 0};
        n_order = 5;
`else
        order   = '{1, 0, 3, 2, 0};
        n_order = 4;
`endif
        for (int i = 0; i < n_order; i++) begin
            #1 chk("contend_ready", 64'(bus.o_req_ready), 64'(4'b0001 << order[i]));
            push(64'h1000 + 64'(order[i]), 5'(10 + order[i]), 2'(order[i]));
            tick();
`ifndef RESULT_ARB_RR_EN
            bus.i_req_valid[order[i]] = 1'b0;
`endif
            chk("contend_src", 64'(bus.o_result_src), 64'(order[i]));
        end
        bus.i_req_valid = 4'h0;
        tick();

        // Backpressure: load entry held while ALU waits
        set_req(1, 64'hAAAA, 5'd7);
        bus.i_req_valid = 4'b0010;
        bus.i_wb_ready  = 1'b0;
        #1 chk("bp_load_ready", 64'(bus.o_req_ready), 64'h2);
        push(64'hAAAA, 5'd7, 2'd1);
        tick();
        set_req(0, 64'hBBBB, 5'd9);
        bus.i_req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_stall_ready", 64'(bus.o_req_ready), 64'h0);
            chk("bp_hold_data", bus.o_wb_data, 64'hAAAA);
            chk("bp_hold_rd", 64'(bus.o_wb_rd), 64'h7);
            chk("bp_hold_src", 64'(bus.o_result_src), 64'h1);
            tick();
        end
        bus.i_wb_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(bus.o_req_ready), 64'h1);
        push(64'hBBBB, 5'd9, 2'd0);
        tick();
        bus.i_req_valid = 4'h0;
        chk("bp_next_src", 64'(bus.o_result_src), 64'h0);
        tick();

        // Back-to-back PC+4 entries
        for (int i = 0; i < 4; i++) begin
            set_req(2, 64'h5000 + 64'(i), 5'(20 + i));
            bus.i_req_valid = 4'b0100;
            #1 chk("b2b_ready", 64'(bus.o_req_ready), 64'h4);
            push(64'h5000 + 64'(i), 5'(20 + i), 2'd2);
            tick();
            chk("b2b_wb_valid", 64'(bus.o_wb_valid), 64'h1);
        end
        bus.i_req_valid = 4'h0;
        tick();
        chk("b2b_drained", 64'(bus.o_wb_valid), 64'h0);

        // Reset during a stall drops the held entry; pending load re-arbitrates after reset
        set_req(0, 64'hCCCC, 5'd3);
        bus.i_req_valid = 4'b0001;
        bus.i_wb_ready  = 1'b0;
        #1 chk("rs_alu_ready", 64'(bus.o_req_ready), 64'h1);
        tick();
        set_req(1, 64'hDDDD, 5'd4);
        bus.i_req_valid = 4'b0010;
        chk("rs_stall_ready", 64'(bus.o_req_ready), 64'h0);
        chk("rs_stall_valid", 64'(bus.o_wb_valid), 64'h1);
        rst = 1'b1;
        #1 chk("rs_rst_ready", 64'(bus.o_req_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1 chk("rs_dropped", 64'(bus.o_wb_valid), 64'h0);
        chk("rs_regrant", 64'(bus.o_req_ready), 64'h2);
        push(64'hDDDD, 5'd4, 2'd1);
        bus.i_wb_ready = 1'b1;
        tick();
        bus.i_req_valid = 4'h0;
        chk("rs_wb_valid", 64'(bus.o_wb_valid), 64'h1);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
